// File: rtl/phoenix_packet_sender_if.sv
// phoenix_packet_sender_if: the core push port, the router credit link and the
// status outputs bundled as one interface.
// The slave modport is the sender itself; master is the core/router side.
// o_pkt_count exists only when PHOENIX_SENDER_PKTCNT_EN is defined.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

interface phoenix_packet_sender_if;
    logic                 i_valid;
    logic [`TAM_FLIT-1:0] i_flit;
    logic                 o_ready;
    logic                 i_credit;
    logic                 o_tx;
    logic [`TAM_FLIT-1:0] o_data;
    logic                 o_busy;
    logic                 o_pkt_done;
`ifdef PHOENIX_SENDER_PKTCNT_EN
    logic [15:0]          o_pkt_count;

    modport master (
        output i_valid, i_flit, i_credit,
        input  o_ready, o_tx, o_data, o_busy, o_pkt_done, o_pkt_count
    );
    modport slave (
        input  i_valid, i_flit, i_credit,
        output o_ready, o_tx, o_data, o_busy, o_pkt_done, o_pkt_count
    );
`else
    modport master (
        output i_valid, i_flit, i_credit,
        input  o_ready, o_tx, o_data, o_busy, o_pkt_done
    );
    modport slave (
        input  i_valid, i_flit, i_credit,
        output o_ready, o_tx, o_data, o_busy, o_pkt_done
    );
`endif
endinterface

// File: rtl/phoenix_packet_sender.sv
// phoenix_packet_sender: transmit end of a Phoenix router credit link.
// The core pushes flits into a small staging FIFO. The head flit goes out
// whenever the router grants credit. A framing FSM follows the
// header / size / payload sequence so it can report completion and busy.
// Optional feature macro: PHOENIX_SENDER_PKTCNT_EN adds a 16-bit packet counter.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module phoenix_packet_sender #(
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    phoenix_packet_sender_if.slave  bus
);
    localparam int W  = `TAM_FLIT;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {HEADER, SIZE, PAYLOAD} state_t;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          has_data, ready, push, pop;
    logic [W-1:0]  head;

    state_t        state_q, state_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          done_q, done_d;

    assign head     = mem[rd_ptr];
    assign has_data = (count != '0);
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign ready    = (count != (AW+1)'(DEPTH));
    assign push     = bus.i_valid & ready;
    // Credit is used combinationally; the router guarantees acceptance.
    assign pop      = has_data & bus.i_credit & ~i_rst;

    assign bus.o_ready    = ready;
    assign bus.o_tx       = pop;
    assign bus.o_data     = head;
    assign bus.o_busy     = (state_q != HEADER) | has_data;
    assign bus.o_pkt_done = done_q;

    // Flit storage: no reset, contents are only meaningful below count.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= bus.i_flit;
    end

    // FIFO pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Framing FSM state, payload counter and done pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HEADER;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Framing next state: advances only on a transferred flit.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (pop) begin
            case (state_q)
                HEADER: state_d = SIZE;
                SIZE: begin
                    rem_d = head;
                    if (head == '0) begin
                        state_d = HEADER;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // rem_q >= 1 here, so the decrement never wraps.
                    rem_d = rem_q - 1'b1;
                    if (rem_q == W'(1)) begin
                        state_d = HEADER;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = HEADER;
            endcase
        end
    end

`ifdef PHOENIX_SENDER_PKTCNT_EN
    logic [15:0] pkt_cnt_q;

    // Completed-packet counter, bumped on the edge that raises the done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst)       pkt_cnt_q <= '0;
        else if (done_d) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end

    assign bus.o_pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_phoenix_packet_sender.sv
// Self-checking bench for phoenix_packet_sender: scenario tasks drive the
// core/link inputs, a scoreboard queue holds pushed flits, and transferred
// flits are compared against it in order.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module tb_phoenix_packet_sender;
    localparam int W = `TAM_FLIT;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    logic         s_tx, s_ready, s_busy, s_done;
    logic [W-1:0] s_data;
`ifdef PHOENIX_SENDER_PKTCNT_EN
    logic [15:0]  s_cnt;
`endif

    phoenix_packet_sender_if bus ();

    phoenix_packet_sender #(.DEPTH(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs, sample outputs at negedge, record pushes and
    // transfers into the scoreboard, then move to just after the next posedge.
    task automatic cyc(input logic v, input logic [W-1:0] f, input logic cr, input logic r);
        bus.i_valid  = v;
        bus.i_flit   = f;
        bus.i_credit = cr;
        rst          = r;
        @(negedge clk);
        s_tx    = bus.o_tx;
        s_ready = bus.o_ready;
        s_busy  = bus.o_busy;
        s_done  = bus.o_pkt_done;
        s_data  = bus.o_data;
`ifdef PHOENIX_SENDER_PKTCNT_EN
        s_cnt   = bus.o_pkt_count;
`endif
        if (v && s_ready && !r) exp_q.push_back(f);
        if (s_tx === 1'b1) got_q.push_back(s_data);
        if (s_done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        checks++; if (s_tx !== 1'b0)    begin errors++; $display("FAIL rst_tx got %b want 0", s_tx); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", s_ready); end
        checks++; if (s_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b want 0", s_busy); end
        checks++; if (s_done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b want 0", s_done); end
        cyc(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_tx !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got tx=%b busy=%b want 0 0", s_tx, s_busy); end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] fl [8];
        logic [W-1:0] e, g;
        int d0;
        fl = '{W'(16'h0011), W'(16'h0002), W'(16'hAAAA), W'(16'hBBBB), '0, '0, '0, '0};
        d0 = done_cnt;
        for (int i = 0; i < 7; i++) begin
            cyc(i < 4, fl[i], 1'b1, 1'b0);
            checks++; if (s_tx !== ((i >= 1 && i <= 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL b2b_tx cyc%0d got %b", i, s_tx); end
            checks++; if (s_done !== ((i == 5) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL b2b_done cyc%0d got %b", i, s_done); end
            if (i == 5) begin
                checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", s_busy); end
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_data got %h want %h", g, e); end
        end
        checks++; if (exp_q.size() != 0 || got_q.size() != 0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL b2b_count left exp=%0d got=%0d done=%0d want 0 0 1", exp_q.size(), got_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_credit_stall();
        logic [W-1:0] fl [9];
        logic         cr [9];
        logic [W-1:0] e, g;
        int d0;
        fl = '{W'(16'h0011), W'(16'h0002), W'(16'hAAAA), W'(16'hBBBB), '0, '0, '0, '0, '0};
        cr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) begin
            cyc(i < 4, fl[i], cr[i], 1'b0);
            if (i >= 3 && i <= 5) begin
                checks++; if (s_tx !== 1'b0 || s_data !== W'(16'hAAAA)) begin errors++; $display("FAIL stall_hold cyc%0d got tx=%b data=%h want 0 aaaa", i, s_tx, s_data); end
            end
            if (i == 6 || i == 7) begin
                checks++; if (s_tx !== 1'b1) begin errors++; $display("FAIL stall_resume cyc%0d got %b want 1", i, s_tx); end
            end
            if (i == 8) begin
                checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", s_done); end
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL stall_data got %h want %h", g, e); end
        end
        checks++; if (exp_q.size() != 0 || got_q.size() != 0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL stall_count left exp=%0d got=%0d done=%0d want 0 0 1", exp_q.size(), got_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_full_fifo();
        logic [W-1:0] fl [5];
        logic [W-1:0] e, g;
        int d0;
        fl = '{W'(16'h0055), W'(16'h0003), W'(16'h0101), W'(16'h0202), W'(16'h0303)};
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, fl[i], 1'b0, 1'b0);
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready cyc%0d got %b want 1", i, s_ready); end
        end
        cyc(1'b1, fl[4], 1'b0, 1'b0);
        checks++; if (s_ready !== 1'b0 || s_tx !== 1'b0) begin errors++; $display("FAIL full_wait got ready=%b tx=%b want 0 0", s_ready, s_tx); end
        cyc(1'b1, fl[4], 1'b1, 1'b0);
        checks++; if (s_ready !== 1'b0 || s_tx !== 1'b1) begin errors++; $display("FAIL full_first_pop got ready=%b tx=%b want 0 1", s_ready, s_tx); end
        cyc(1'b1, fl[4], 1'b1, 1'b0);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b want 1", s_ready); end
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL full_data got %h want %h", g, e); end
        end
        checks++; if (exp_q.size() != 0 || got_q.size() != 0 || done_cnt - d0 != 1) begin
            errors++; $display("FAIL full_count left exp=%0d got=%0d done=%0d want 0 0 1", exp_q.size(), got_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_zero_size();
        logic [W-1:0] e, g;
        cyc(1'b1, W'(16'h0022), 1'b1, 1'b0);
        cyc(1'b1, W'(16'h0000), 1'b1, 1'b0);
        cyc(1'b1, W'(16'h0033), 1'b1, 1'b0);
        checks++; if (s_tx !== 1'b1 || s_data !== W'(16'h0000) || s_done !== 1'b0) begin errors++; $display("FAIL zero_size_tx got tx=%b data=%h done=%b", s_tx, s_data, s_done); end
        cyc(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", s_done); end
        checks++; if (s_tx !== 1'b1 || s_data !== W'(16'h0033)) begin errors++; $display("FAIL zero_hdr_tx got tx=%b data=%h want 1 0033", s_tx, s_data); end
        cyc(1'b0, '0, 1'b1, 1'b0);
        // FIFO empty here, so busy high means the FSM sits in SIZE.
        checks++; if (s_busy !== 1'b1 || s_tx !== 1'b0 || s_done !== 1'b0) begin errors++; $display("FAIL zero_in_size got busy=%b tx=%b done=%b want 1 0 0", s_busy, s_tx, s_done); end
        cyc(1'b1, W'(16'h0000), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_done !== 1'b1 || s_busy !== 1'b0) begin errors++; $display("FAIL zero_close got done=%b busy=%b want 1 0", s_done, s_busy); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL zero_data got %h want %h", g, e); end
        end
        checks++; if (exp_q.size() != 0 || got_q.size() != 0) begin errors++; $display("FAIL zero_left exp=%0d got=%0d want 0 0", exp_q.size(), got_q.size()); end
    endtask

    task automatic test_reset_mid_payload();
        logic [W-1:0] e, g;
        int d0;
        cyc(1'b1, W'(16'h0066), 1'b1, 1'b0);
        cyc(1'b1, W'(16'h0003), 1'b1, 1'b0);
        cyc(1'b1, W'(16'hD001), 1'b1, 1'b0);
        cyc(1'b1, W'(16'hD002), 1'b1, 1'b0);
        checks++; if (s_tx !== 1'b1 || s_data !== W'(16'hD001)) begin errors++; $display("FAIL rmp_first_payload got tx=%b data=%h", s_tx, s_data); end
        cyc(1'b0, '0, 1'b1, 1'b1);
        checks++; if (s_tx !== 1'b0) begin errors++; $display("FAIL rmp_tx_in_reset got %b want 0", s_tx); end
        cyc(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_busy !== 1'b0 || s_tx !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL rmp_after got busy=%b tx=%b ready=%b want 0 0 1", s_busy, s_tx, s_ready); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL rmp_data got %h want %h", g, e); end
        end
        // The unsent payload flit was discarded by reset.
        checks++; if (exp_q.size() != 1 || got_q.size() != 0) begin errors++; $display("FAIL rmp_flush exp=%0d got=%0d want 1 0", exp_q.size(), got_q.size()); end
        exp_q.delete();
        d0 = done_cnt;
        cyc(1'b1, W'(16'h0044), 1'b1, 1'b0);
        cyc(1'b1, W'(16'h0001), 1'b1, 1'b0);
        cyc(1'b1, W'(16'hCCCC), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        checks++; if (done_cnt - d0 != 1 || s_busy !== 1'b0) begin errors++; $display("FAIL rmp_fresh got done=%0d busy=%b want 1 0", done_cnt - d0, s_busy); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL rmp_fresh_data got %h want %h", g, e); end
        end
        checks++; if (exp_q.size() != 0 || got_q.size() != 0) begin errors++; $display("FAIL rmp_left exp=%0d got=%0d want 0 0", exp_q.size(), got_q.size()); end
    endtask

`ifdef PHOENIX_SENDER_PKTCNT_EN
    task automatic test_pkt_count();
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_cnt !== 16'd0) begin errors++; $display("FAIL cnt_reset got %h want 0", s_cnt); end
        for (int p = 0; p < 3; p++) begin
            cyc(1'b1, W'(16'h0070 + p), 1'b1, 1'b0);
            cyc(1'b1, W'(16'h0000), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_cnt !== 16'd3) begin errors++; $display("FAIL cnt_three got %h want 3", s_cnt); end
        force dut.pkt_cnt_q = 16'hFFFF;
        cyc(1'b0, '0, 1'b1, 1'b0);
        release dut.pkt_cnt_q;
        cyc(1'b1, W'(16'h0077), 1'b1, 1'b0);
        cyc(1'b1, W'(16'h0000), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_cnt !== 16'd0) begin errors++; $display("FAIL cnt_wrap got %h want 0", s_cnt); end
        exp_q.delete();
        got_q.delete();
    endtask
`endif

    initial begin
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_flit   = '0;
        bus.i_credit = 1'b0;
        test_reset();
        test_back_to_back();
        test_credit_stall();
        test_full_fifo();
        test_zero_size();
        test_reset_mid_payload();
`ifdef PHOENIX_SENDER_PKTCNT_EN
        test_pkt_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phoenix_packet_sender.md
# phoenix_packet_sender

- Injects packets from a local core into one input port of a Phoenix router. This is the transmit end of the router's credit-based link.
- Accepts flits from the core over a valid/ready interface and stages them in a small FIFO.
- Drives them onto the link as `o_tx`/`o_data` whenever the router grants credit.
- Tracks Phoenix packet framing (header flit, size flit, payload), so it can report packet completion and busy status to the core.

## Interface
- `DEPTH`, default 4: staging FIFO depth in flits; power of two, ≥2.
- Flit width is `` `TAM_FLIT ``, from `defines.vh`.
- `i_clk`  input  1  single clock; core side and link side both use it.
- `i_rst`  input  1  reset; synchronous, active-high.
- `i_valid`  input  1  core presents a flit on `i_flit`.
- `i_flit`  input  `` `TAM_FLIT ``  flit from core.
- `o_ready`  output  1  FIFO can accept a flit this cycle.
- `i_credit`  input  1  router input buffer has space (router's `o_credit`).
- `o_tx`  output  1  flit on `o_data` is transferred this cycle (drives router `i_rx`).
- `o_data`  output  `` `TAM_FLIT ``  FIFO head flit.
- `o_busy`  output  1  a packet is in progress or the FIFO is non-empty.
- `o_pkt_done`  output  1  one-cycle pulse after the last flit of a packet is sent.
- `o_pkt_count`  output  16  packets sent; present only with `PHOENIX_SENDER_PKTCNT_EN`.

## Operation
- **Core-side push:** a flit is pushed when `i_valid & o_ready`.
  - `o_ready = (count != DEPTH)`.
  - There is no bypass when the FIFO is full, even if a pop occurs the same cycle.
- **Link-side pop:**
  - `o_tx = has_data & i_credit & !i_rst` (combinational).
  - Each cycle with `o_tx` high transfers exactly one flit and pops the FIFO.
- **Push and pop in the same cycle:** count is unchanged; both flits are handled correctly, including at count = 1.
- **`o_data`** always equals the FIFO head. It holds stable while `o_tx` is low.
- **Framing FSM** advances only on cycles with `o_tx` high:
  - `HEADER`: the sent flit is the header (target address). Go to `SIZE`.
  - `SIZE`: the sent flit value loads the payload counter `remaining`.
    - If the value is 0, go to `HEADER` and set the done pulse.
    - Otherwise go to `PAYLOAD`.
  - `PAYLOAD`: decrement `remaining`.
    - When a flit is sent with `remaining == 1`, go to `HEADER` and set the done pulse.
- `remaining` is `` `TAM_FLIT `` bits wide.
  - Maximum payload is 2^`` `TAM_FLIT ``−1 flits.
  - No wrap is possible, because decrement only happens while `remaining ≥ 1`.
- `o_pkt_done` is a register: high for exactly the one cycle following the last-flit transfer.
- `o_busy = (state != HEADER) | has_data` (combinational).
- The block never reorders, drops or duplicates flits. The core is responsible for well-formed packets.
- **Reset** while `i_rst` is high:
  - FIFO is emptied and the FSM goes to `HEADER`.
  - `remaining` = 0; `o_pkt_done` = 0; `o_pkt_count` = 0.
  - `o_tx` is forced to 0 during any cycle `i_rst` is high.
- **Reset values of outputs:** `o_ready` = 1, `o_tx` = 0, `o_data` = don't-care (FIFO storage is not cleared), `o_busy` = 0, `o_pkt_done` = 0.
- **Reset mid-packet:** the partial packet is abandoned. The next flit pushed is treated as a header.

## Timing
- Flit latency from core to link: a flit pushed at edge N can appear with `o_tx` high in cycle N+1 at the earliest. Storage is registered; there is no same-cycle flow-through.
- Throughput: one flit per cycle while `i_credit` stays high and the FIFO is non-empty.
- `i_credit` is sampled combinationally. A deasserted credit blocks the transfer in that same cycle.
- **Credit rule:** the router guarantees that if `i_credit` is high in a cycle, a flit sent in that cycle is accepted. The sender keeps no credit counter of its own.
- `o_pkt_done`: edge after the last transfer.
- `o_pkt_count`: increments on the same edge that sets `o_pkt_done`.

## Configuration
- Macro: `PHOENIX_SENDER_PKTCNT_EN`.
- **Defined:**
  - `o_pkt_count` exists as a 16-bit register.
  - It increments by 1 per completed packet and wraps 0xFFFF→0.
  - It is cleared by reset.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
1. **Back-to-back packet:** `i_credit` held 1; push 0x0011, 0x0002, 0xAAAA, 0xBBBB on consecutive cycles.
   - `o_tx` high for 4 consecutive cycles starting one cycle after the first push, with `o_data` in that order.
   - `o_pkt_done` high for one cycle after the 0xBBBB transfer.
   - `o_busy` returns to 0 with it.
2. **Credit stall:** same packet; `i_credit` = 0 for 3 cycles after the size flit is sent.
   - `o_tx` = 0 and `o_data` = 0xAAAA held for those 3 cycles.
   - Transfer resumes on credit return; nothing lost or duplicated.
3. **Full FIFO:** `DEPTH`=4, `i_credit`=0; push 5 flits.
   - `o_ready` falls after the 4th push and the 5th flit waits.
   - Raise `i_credit`: `o_ready` = 1 the cycle after the first pop, and all 5 flits exit in order.
4. **Zero-size packet:** push 0x0022, 0x0000, then 0x0033.
   - `o_pkt_done` fires after the 0x0000 transfer.
   - 0x0033 is treated as a new header: FSM goes to `SIZE` after it is sent.
5. **Reset mid-payload:** assert `i_rst` for 1 cycle after 1 of 3 payload flits has been sent.
   - `o_tx` = 0 during reset; afterwards `o_busy` = 0 and the FIFO is empty.
   - A fresh packet 0x0044, 0x0001, 0xCCCC completes with a single `o_pkt_done`.
6. **Packet counter (`PHOENIX_SENDER_PKTCNT_EN`):**
   - Send 3 packets: `o_pkt_count` reads 3.
   - Force to 0xFFFF, then send 1 packet: reads 0.
